// File: rtl/buffer_framer.sv
// rtl/buffer_framer.sv - drains a buffer_AA read port into header/payload/trailer frames
// Optional checksum word before the trailer: define FRAMER_CHECKSUM_EN.
module buffer_framer #(
  parameter int WDTH      = 32,
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read_full,
  input  logic [WDTH-1:0] read_data,
  output logic            read_delete,
  output logic [WDTH-1:0] out_data,
  output logic            out_nd,
  output logic            busy
);

  localparam int SW = WDTH - 8;
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BODY    = 2'd1,
    S_TRAILER = 2'd2
`ifdef FRAMER_CHECKSUM_EN
    , S_CKSUM = 2'd3
`endif
  } state_t;

`ifdef FRAMER_CHECKSUM_EN
  localparam state_t S_CLOSE = S_CKSUM;
`else
  localparam state_t S_CLOSE = S_TRAILER;
`endif

  state_t          r_state;
  logic            r_read_delete;
  logic            r_out_nd;
  logic [WDTH-1:0] r_out_data;
  logic [7:0]      r_count;
  logic [IW-1:0]   r_idle_cnt;
  logic [SW-1:0]   r_seq;
`ifdef FRAMER_CHECKSUM_EN
  logic [WDTH-1:0] r_cksum;
`endif

  logic w_take;
  logic w_last;
  logic w_idle_expired;

  // The head word is stale right after a pop, so a pop is never issued back-to-back.
  assign w_take         = read_full && !r_read_delete;
  assign w_last         = (r_count == 8'(FRAME_LEN - 1));
  assign w_idle_expired = (r_idle_cnt == IW'(TIMEOUT - 1));

  assign read_delete = r_read_delete;
  assign out_nd      = r_out_nd;
  assign out_data    = r_out_data;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_read_delete <= 1'b0;
      r_out_nd      <= 1'b0;
      r_out_data    <= '0;
      r_count       <= '0;
      r_idle_cnt    <= '0;
      r_seq         <= '0;
`ifdef FRAMER_CHECKSUM_EN
      r_cksum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_read_delete <= 1'b0;
          if (read_full) begin
            r_out_nd   <= 1'b1;
            r_out_data <= {8'hA5, r_seq};
            r_state    <= S_BODY;
`ifdef FRAMER_CHECKSUM_EN
            r_cksum    <= '0;
`endif
          end else begin
            r_out_nd <= 1'b0;
          end
        end

        S_BODY: begin
          if (w_take) begin
            r_read_delete <= 1'b1;
            r_out_nd      <= 1'b1;
            r_out_data    <= read_data;
            r_count       <= r_count + 8'd1;
            r_idle_cnt    <= '0;
`ifdef FRAMER_CHECKSUM_EN
            r_cksum       <= r_cksum ^ read_data;
`endif
            if (w_last) begin
              r_state <= S_CLOSE;
            end
          end else begin
            r_read_delete <= 1'b0;
            r_out_nd      <= 1'b0;
            // Saturates so an empty frame waiting for its first word cannot wrap.
            if (w_idle_expired) begin
              if (r_count != 8'd0) begin
                r_state <= S_CLOSE;
              end
            end else begin
              r_idle_cnt <= r_idle_cnt + IW'(1);
            end
          end
        end

`ifdef FRAMER_CHECKSUM_EN
        S_CKSUM: begin
          r_read_delete <= 1'b0;
          r_out_nd      <= 1'b1;
          r_out_data    <= r_cksum;
          r_state       <= S_TRAILER;
        end
`endif

        S_TRAILER: begin
          r_read_delete <= 1'b0;
          r_out_nd      <= 1'b1;
          r_out_data    <= {8'h5A, SW'(r_count)};
          r_seq         <= r_seq + SW'(1);
          r_count       <= '0;
          r_idle_cnt    <= '0;
          r_state       <= S_IDLE;
        end

        default: begin
          r_read_delete <= 1'b0;
          r_out_nd      <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
